// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

   // RISC-V load funct3 codes
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // RISC-V store funct3 codes
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } lsu_state_e;

   typedef struct packed {
      logic        store;
      logic [2:0]  funct3;
      logic [31:0] addr;
      logic [31:0] wdata;
   } lsu_req_t;

   // A request faults on an unknown width code, a misaligned half/word,
   // or a word index past the end of data memory.
   function automatic logic req_fault(input lsu_req_t r, input logic [31:0] words);
      logic bad_f3;
      logic misal;
      logic oor;
      if (r.store) bad_f3 = (r.funct3 > F3_SW);
      else         bad_f3 = (r.funct3 == 3'b011) || (r.funct3 == 3'b110) ||
                            (r.funct3 == 3'b111);
      case (r.funct3[1:0])
         2'b01:   misal = r.addr[0];
         2'b10:   misal = |r.addr[1:0];
         default: misal = 1'b0;
      endcase
      oor = ({2'b00, r.addr[31:2]} >= words);
      return bad_f3 | misal | oor;
   endfunction

endpackage

// File: rtl/load_align.sv
// Byte-lane alignment and sign/zero extension of a loaded memory word.
module load_align
   import lsu_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   logic [31:0] shifted;

   // Bring the addressed byte/half down to bit 0, then extend by width code.
   always_comb begin
      shifted = word_i >> {off_i, 3'b000};
      case (funct3_i)
         F3_LB:   data_o = {{24{shifted[7]}}, shifted[7:0]};
         F3_LH:   data_o = {{16{shifted[15]}}, shifted[15:0]};
         F3_LW:   data_o = shifted;
         F3_LBU:  data_o = {24'h0, shifted[7:0]};
         F3_LHU:  data_o = {16'h0, shifted[15:0]};
         default: data_o = 32'h0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: IDLE -> ACCESS -> RESP, or straight
// to RESP for a faulting request without touching memory.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DMEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic        busy,
   output logic        dmem_sel,
   output logic        wr,
   output logic [3:0]  mask,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_data_wr,
   input  logic [31:0] dmem_data_rd
);

   lsu_state_e  state_q, state_d;
   lsu_req_t    req_q, req_d;
   logic [31:0] rdata_q, rdata_d;
   logic        fault_q, fault_d;

   lsu_req_t    req_in;
   logic        in_fault;
   logic [31:0] load_data;
   logic        access;

   assign req_in   = '{store: req_store, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
   assign in_fault = req_fault(req_in, 32'(DMEM_WORDS));
   assign access   = (state_q == ST_ACCESS);

   load_align u_align (
      .word_i   (dmem_data_rd),
      .off_i    (req_q.addr[1:0]),
      .funct3_i (req_q.funct3),
      .data_o   (load_data)
   );

   // State, captured request and response registers; reset kills any
   // in-flight access immediately so no write can commit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         req_q   <= '0;
         rdata_q <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         rdata_q <= rdata_d;
         fault_q <= fault_d;
      end
   end

   // Next-state: request inputs are only looked at in IDLE; response holds in RESP.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      rdata_d = rdata_q;
      fault_d = fault_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               req_d = req_in;
               if (in_fault) begin
                  state_d = ST_RESP;
                  fault_d = 1'b1;
                  rdata_d = 32'h0;
               end else begin
                  state_d = ST_ACCESS;
               end
            end
         end
         ST_ACCESS: begin
            state_d = ST_RESP;
            fault_d = 1'b0;
            rdata_d = req_q.store ? 32'h0 : load_data;
         end
         ST_RESP: begin
            if (resp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Store lane enables and lane-replicated write data.
   always_comb begin
      mask         = 4'b0000;
      dmem_data_wr = req_q.wdata;
      case (req_q.funct3)
         F3_SB:   dmem_data_wr = {4{req_q.wdata[7:0]}};
         F3_SH:   dmem_data_wr = {2{req_q.wdata[15:0]}};
         default: dmem_data_wr = req_q.wdata;
      endcase
      if (access && req_q.store) begin
         case (req_q.funct3)
            F3_SB:   mask = 4'b0001 << req_q.addr[1:0];
            F3_SH:   mask = req_q.addr[1] ? 4'b1100 : 4'b0011;
            F3_SW:   mask = 4'b1111;
            default: mask = 4'b0000;
         endcase
      end
   end

   assign dmem_sel   = access;
   assign wr         = req_q.store;
   assign dmem_addr  = req_q.addr;
   assign req_ready  = (state_q == ST_IDLE) & rst;
   assign busy       = (state_q != ST_IDLE);
   assign resp_valid = (state_q == ST_RESP);
   assign resp_rdata = rdata_q;
   assign resp_fault = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset/hold sequences,
// and random traffic checked against a byte-array memory model.
module tb_load_store_unit;
   import lsu_pkg::*;

   localparam int WORDS = 64;

   logic        clk, rst;
   logic        req_valid, req_ready, req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_fault, busy;
   logic [31:0] resp_rdata;
   logic        dmem_sel, wr;
   logic [3:0]  mask;
   logic [31:0] dmem_addr, dmem_data_wr, dmem_data_rd;

   int n_cmp = 0;
   int n_fail = 0;

   logic [31:0] mem [0:WORDS-1];
   logic [7:0]  ref_b [0:4*WORDS-1];
   logic        mem_clr;

   typedef struct {
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      int          hold;
      logic        ef;
      logic [31:0] erd;
      logic [3:0]  emk;
      logic [31:0] edw;
   } vec_t;
   vec_t tbl[$];

   load_store_unit #(.DMEM_WORDS(WORDS)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_fault(resp_fault), .busy(busy),
      .dmem_sel(dmem_sel), .wr(wr), .mask(mask), .dmem_addr(dmem_addr),
      .dmem_data_wr(dmem_data_wr), .dmem_data_rd(dmem_data_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory the DUT talks to: combinational read, write on negedge.
   always_comb begin
      if ({2'b00, dmem_addr[31:2]} < 32'(WORDS)) dmem_data_rd = mem[dmem_addr[7:2]];
      else                                        dmem_data_rd = 32'h0;
   end

   always @(negedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < WORDS; i++) mem[i] <= 32'h0;
      end else if (dmem_sel && wr && ({2'b00, dmem_addr[31:2]} < 32'(WORDS))) begin
         for (int l = 0; l < 4; l++)
            if (mask[l]) mem[dmem_addr[7:2]][8*l +: 8] <= dmem_data_wr[8*l +: 8];
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: bound expired", name);
   endtask

   // Reference: byte-addressed memory, access size from the width code.
   task automatic ref_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic flt, output logic [31:0] rd);
      int size;
      logic [31:0] v;
      flt = 1'b0;
      rd  = 32'h0;
      if (st) flt = (f3 > 3'd2);
      else    flt = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      if ((a % size) != 0) flt = 1'b1;
      if ((a / 4) >= WORDS) flt = 1'b1;
      if (flt) return;
      if (st) begin
         for (int i = 0; i < size; i++) ref_b[a + i] = wd[8*i +: 8];
      end else begin
         v = 32'h0;
         for (int i = 0; i < size; i++) v = v | (32'(ref_b[a + i]) << (8 * i));
         if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFFFFFF << (8 * size));
         rd = v;
      end
   endtask

   task automatic add(input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input int hold, input logic ef,
                      input logic [31:0] erd, input logic [3:0] emk, input logic [31:0] edw);
      vec_t v;
      v.st = st; v.f3 = f3; v.a = a; v.wd = wd; v.hold = hold;
      v.ef = ef; v.erd = erd; v.emk = emk; v.edw = edw;
      tbl.push_back(v);
   endtask

   // One full request/response transaction with all checks along the way.
   task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int hold, input logic ef,
                        input logic [31:0] erd, input logic chk_bus,
                        input logic [3:0] emk, input logic [31:0] edw);
      int t;
      logic sel;
      logic [3:0] mk;
      logic [31:0] dw;
      sel = 1'b0; mk = 4'h0; dw = 32'h0; t = 0;
      @(negedge clk);
      while (!req_ready && t < 20) begin @(negedge clk); t++; end
      if (!req_ready) begin fail_now("req_ready_timeout"); return; end
      req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clk); #1;
      // Scribble the request bus; the unit must ignore it now.
      req_valid  = 1'b0;
      req_store  = 1'($urandom_range(0, 1));
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      resp_ready = 1'($urandom_range(0, 1));
      t = 0;
      do begin
         @(negedge clk); t++;
         if (dmem_sel) begin sel = 1'b1; mk = mask; dw = dmem_data_wr; end
      end while (!resp_valid && t < 10);
      if (!resp_valid) begin resp_ready = 1'b0; fail_now("resp_timeout"); return; end
      check("latency", 32'(t), ef ? 32'd1 : 32'd2);
      check("fault", 32'(resp_fault), 32'(ef));
      check("rdata", resp_rdata, erd);
      check("dmem_sel_seen", 32'(sel), 32'(!ef));
      if (chk_bus && !ef) begin
         check("mask", 32'(mk), 32'(emk));
         if (st) check("dmem_data_wr", dw, edw);
      end
      resp_ready = (hold == 0);
      for (int h = 0; h < hold; h++) begin
         // A pending request must wait while the response is held.
         req_valid = 1'b1; req_store = 1'b1; req_funct3 = F3_SW;
         req_addr = 32'h0; req_wdata = 32'hFFFFFFFF;
         @(negedge clk);
         check("hold_valid", 32'(resp_valid), 32'd1);
         check("hold_fault", 32'(resp_fault), 32'(ef));
         check("hold_rdata", resp_rdata, erd);
         check("hold_req_ready", 32'(req_ready), 32'd0);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   initial begin
      logic        ef, st;
      logic [31:0] erd, a, wd;
      logic [2:0]  f3;
      int          r;

      rst = 1'b0; mem_clr = 1'b1;
      req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'h0;
      req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
      for (int i = 0; i < 4*WORDS; i++) ref_b[i] = 8'h00;

      // Reset state
      #1;
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_dmem_sel", 32'(dmem_sel), 32'd0);
      check("rst_wr", 32'(wr), 32'd0);
      check("rst_mask", 32'(mask), 32'd0);
      check("rst_dmem_addr", dmem_addr, 32'h0);
      check("rst_dmem_data_wr", dmem_data_wr, 32'h0);
      check("rst_resp_rdata", resp_rdata, 32'h0);
      check("rst_resp_fault", 32'(resp_fault), 32'd0);
      #11;
      rst = 1'b1; mem_clr = 1'b0;
      @(negedge clk);
      check("idle_req_ready", 32'(req_ready), 32'd1);

      // Directed vectors (share memory state in order)
      add(1, F3_SW,  32'h10,  32'hDEADBEEF, 0, 0, 32'h0,        4'hF, 32'hDEADBEEF);
      add(1, F3_SB,  32'h13,  32'h000000A5, 0, 0, 32'h0,        4'h8, 32'hA5A5A5A5);
      add(0, F3_LW,  32'h10,  32'h0,        0, 0, 32'hA5ADBEEF, 4'h0, 32'h0);
      add(0, F3_LB,  32'h13,  32'h0,        0, 0, 32'hFFFFFFA5, 4'h0, 32'h0);
      add(0, F3_LBU, 32'h13,  32'h0,        0, 0, 32'h000000A5, 4'h0, 32'h0);
      add(0, F3_LH,  32'h12,  32'h0,        0, 0, 32'hFFFFA5AD, 4'h0, 32'h0);
      add(0, F3_LHU, 32'h12,  32'h0,        0, 0, 32'h0000A5AD, 4'h0, 32'h0);
      add(0, F3_LW,  32'h102, 32'h0,        0, 1, 32'h0,        4'h0, 32'h0);
      add(1, F3_SH,  32'h11,  32'h00001234, 0, 1, 32'h0,        4'h0, 32'h0);
      add(1, F3_SH,  32'h12,  32'hCAFE1234, 0, 0, 32'h0,        4'hC, 32'h12341234);
      add(0, F3_LW,  32'h10,  32'h0,        0, 0, 32'h1234BEEF, 4'h0, 32'h0);
      add(0, F3_LB,  32'h11,  32'h0,        0, 0, 32'hFFFFFFBE, 4'h0, 32'h0);
      add(0, 3'b011, 32'h0,   32'h0,        0, 1, 32'h0,        4'h0, 32'h0);
      add(1, 3'b100, 32'h0,   32'h0,        0, 1, 32'h0,        4'h0, 32'h0);
      add(0, F3_LW,  32'hFC,  32'h0,        0, 0, 32'h0,        4'h0, 32'h0);
      add(1, F3_SB,  32'hFF,  32'h00000077, 0, 0, 32'h0,        4'h8, 32'h77777777);
      add(0, F3_LBU, 32'hFF,  32'h0,        0, 0, 32'h00000077, 4'h0, 32'h0);
      add(0, F3_LW,  32'hFC,  32'h0,        0, 0, 32'h77000000, 4'h0, 32'h0);
      add(0, F3_LW,  32'h100, 32'h0,        3, 1, 32'h0,        4'h0, 32'h0);
      add(0, F3_LH,  32'h13,  32'h0,        0, 1, 32'h0,        4'h0, 32'h0);
      add(0, F3_LB,  32'h100, 32'h0,        0, 1, 32'h0,        4'h0, 32'h0);
      add(1, F3_SW,  32'h14,  32'h0BADF00D, 2, 0, 32'h0,        4'hF, 32'h0BADF00D);
      add(1, F3_SW,  32'h20,  32'hAAAA5555, 0, 0, 32'h0,        4'hF, 32'hAAAA5555);
      foreach (tbl[i]) begin
         ref_op(tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd, ef, erd);
         do_op(tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd, tbl[i].hold,
               tbl[i].ef, tbl[i].erd, 1'b1, tbl[i].emk, tbl[i].edw);
      end

      // Reset during the ACCESS cycle of a store: nothing may commit.
      @(negedge clk);
      req_valid = 1'b1; req_store = 1'b1; req_funct3 = F3_SW;
      req_addr = 32'h20; req_wdata = 32'h12345678;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("mid_rst_pre_sel", 32'(dmem_sel), 32'd1);
      check("mid_rst_pre_wr", 32'(wr), 32'd1);
      #1 rst = 1'b0;
      #1;
      check("mid_rst_sel", 32'(dmem_sel), 32'd0);
      check("mid_rst_wr", 32'(wr), 32'd0);
      check("mid_rst_mask", 32'(mask), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk); @(negedge clk);
      #1 rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst_resp_valid", 32'(resp_valid), 32'd0);
         check("post_rst_req_ready", 32'(req_ready), 32'd1);
      end
      check("post_rst_mem20", mem[8], 32'hAAAA5555);

      // Random traffic against the byte-array model
      for (int i = 0; i < 300; i++) begin
         st = 1'($urandom_range(0, 1));
         r  = int'($urandom_range(0, 9));
         f3 = (r < 8) ? 3'(r) : (st ? F3_SW : F3_LW);
         a  = 32'($urandom_range(0, 32'h10F));
         if ($urandom_range(0, 3) != 0)
            a = a & ~((f3[1:0] == 2'd2) ? 32'd3 : (f3[1:0] == 2'd1) ? 32'd1 : 32'd0);
         wd = $urandom;
         ref_op(st, f3, a, wd, ef, erd);
         do_op(st, f3, a, wd, int'($urandom_range(0, 2)), ef, erd, 1'b0, 4'h0, 32'h0);
      end

      // Final memory image against the model
      @(negedge clk);
      for (int w = 0; w < WORDS; w++)
         check("mem_image", mem[w], {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
